// File: rtl/sram_responder.sv
`timescale 1ns/1ps
// sram_responder: behavioural model of an asynchronous-style SRAM seen through a
// registered controller interface. Byte-maskable writes commit in one cycle; reads
// present data READ_LAT cycles after the request is sampled and hold it while the
// request stays stable.
//
// Ports
//   clock       single clock, all state changes on posedge
//   reset       asynchronous active-low reset
//   addr        word address; only addr[ADDR_USED-1:0] indexes storage
//   data        bidirectional data bus, driven only while a read is being presented
//   wre, oute   active-low write enable / output enable
//   hb_mask     active-low enable for data[15:8]
//   lb_mask     active-low enable for data[7:0]
//   chip_en     active-low chip select; when high every other input is ignored
//   ready       high while read data is valid on the bus
//   conflict    sticky: wre and oute were both low in one sampled cycle
//   access_cnt  number of accepted writes plus read starts, wrapping
module sram_responder #(
    parameter int unsigned ADDR_USED = 12,
    parameter int unsigned READ_LAT  = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [17:0] addr,
    inout  wire  [15:0] data,
    input  logic        wre,
    input  logic        oute,
    input  logic        hb_mask,
    input  logic        lb_mask,
    input  logic        chip_en,
    output logic        ready,
    output logic        conflict,
    output logic [15:0] access_cnt
);

    localparam int unsigned Depth = 1 << ADDR_USED;
    // Wait states spent in READ_WAIT before DRIVE (counter runs down to zero).
    localparam logic [1:0] LatInit = (READ_LAT >= 2) ? 2'(READ_LAT - 2) : 2'd0;

    typedef enum logic [1:0] {
        StIdle,
        StReadWait,
        StDrive
    } state_e;

    state_e      state_q, state_d;
    logic [17:0] addr_q, addr_d;
    logic [1:0]  lat_cnt_q, lat_cnt_d;
    logic [15:0] rdata_q, rdata_d;
    logic        ready_q, ready_d;
    logic        conflict_q, conflict_d;
    logic [15:0] cnt_q, cnt_d;

    logic [15:0] mem [Depth];

    logic sel;
    logic wr_acc;
    logic read_start;
    logic enter_drive;
    logic drive_hi;
    logic drive_lo;

    assign sel    = ~chip_en;
    assign wr_acc = sel & ~wre;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            lat_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            lat_cnt_q <= lat_cnt_d;
        end
    end

    // Next-state logic. Deselect, write and output-disable all end a read; a write
    // wins over any read in progress.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        lat_cnt_d  = lat_cnt_q;
        read_start = 1'b0;
        if (!sel || !wre || oute) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    read_start = 1'b1;
                end
                StReadWait: begin
                    if (lat_cnt_q == 2'd0) begin
                        state_d = StDrive;
                    end else begin
                        lat_cnt_d = lat_cnt_q - 2'd1;
                    end
                end
                StDrive: begin
                    // New address while presenting data restarts the full latency.
                    if (addr != addr_q) begin
                        read_start = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
        if (read_start) begin
            addr_d = addr;
            if (READ_LAT == 1) begin
                state_d = StDrive;
            end else begin
                state_d   = StReadWait;
                lat_cnt_d = LatInit;
            end
        end
    end

    // Datapath next state: read data is captured once, on entry to DRIVE.
    always_comb begin
        enter_drive = (state_d == StDrive) && ((state_q != StDrive) || read_start);
        rdata_d     = enter_drive ? mem[addr_d[ADDR_USED-1:0]] : rdata_q;
        ready_d     = (state_d == StDrive);
        conflict_d  = conflict_q | (sel & ~wre & ~oute);
        cnt_d       = (wr_acc || read_start) ? cnt_q + 16'd1 : cnt_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdata_q    <= '0;
            ready_q    <= 1'b0;
            conflict_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            rdata_q    <= rdata_d;
            ready_q    <= ready_d;
            conflict_q <= conflict_d;
            cnt_q      <= cnt_d;
        end
    end

    // Storage is never reset so contents survive a reset pulse.
    always_ff @(posedge clock) begin
        if (wr_acc) begin
            if (!hb_mask) begin
                mem[addr[ADDR_USED-1:0]][15:8] <= data[15:8];
            end
            if (!lb_mask) begin
                mem[addr[ADDR_USED-1:0]][7:0] <= data[7:0];
            end
        end
    end

    // Outputs. Bus lanes are gated combinationally so they release in the same
    // cycle a control input deasserts, and immediately on reset via state_q.
    always_comb begin
        drive_hi   = (state_q == StDrive) & sel & ~oute & wre & ~hb_mask;
        drive_lo   = (state_q == StDrive) & sel & ~oute & wre & ~lb_mask;
        ready      = ready_q;
        conflict   = conflict_q;
        access_cnt = cnt_q;
    end

    assign data[15:8] = drive_hi ? rdata_q[15:8] : 8'bzzzz_zzzz;
    assign data[7:0]  = drive_lo ? rdata_q[7:0]  : 8'bzzzz_zzzz;

endmodule

// File: tb/tb_sram_responder.sv
`timescale 1ns/1ps
// Self-checking bench for sram_responder. Expected read data is pushed to a
// scoreboard queue when a read is issued and popped when ready is observed.
// The bus carries weak pull-ups, so a released lane reads back as 8'hFF.
module tb_sram_responder;

    localparam int unsigned ADDR_USED = 12;
    localparam int unsigned READ_LAT  = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic [17:0] addr;
    wire  [15:0] data;
    logic        wre, oute, hb_mask, lb_mask, chip_en;
    logic        ready, conflict;
    logic [15:0] access_cnt;

    logic        tb_drive;
    logic [15:0] tb_wdata;

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] exp_cnt;
    logic [15:0] sb_q[$];

    sram_responder #(
        .ADDR_USED(ADDR_USED),
        .READ_LAT (READ_LAT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .addr      (addr),
        .data      (data),
        .wre       (wre),
        .oute      (oute),
        .hb_mask   (hb_mask),
        .lb_mask   (lb_mask),
        .chip_en   (chip_en),
        .ready     (ready),
        .conflict  (conflict),
        .access_cnt(access_cnt)
    );

    assign data = tb_drive ? tb_wdata : 16'hzzzz;

    for (genvar i = 0; i < 16; i++) begin : g_pu
        pullup (data[i]);
    end

    always #5 clock = ~clock;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic go_idle();
        chip_en  = 1'b1;
        wre      = 1'b1;
        oute     = 1'b1;
        hb_mask  = 1'b0;
        lb_mask  = 1'b0;
        tb_drive = 1'b0;
    endtask

    task automatic do_write(input logic [17:0] a, input logic [15:0] d,
                            input logic hm, input logic lm, input logic oe);
        chip_en  = 1'b0;
        wre      = 1'b0;
        oute     = oe;
        addr     = a;
        hb_mask  = hm;
        lb_mask  = lm;
        tb_wdata = d;
        tb_drive = 1'b1;
        exp_cnt++;
        tick();
        go_idle();
    endtask

    task automatic start_read(input logic [17:0] a, input logic hm, input logic lm,
                              input logic [15:0] stored);
        chip_en  = 1'b0;
        wre      = 1'b1;
        oute     = 1'b0;
        addr     = a;
        hb_mask  = hm;
        lb_mask  = lm;
        tb_drive = 1'b0;
        exp_cnt++;
        sb_q.push_back({hm ? 8'hFF : stored[15:8], lm ? 8'hFF : stored[7:0]});
    endtask

    // Returns the number of edges until ready was seen, or 99 if it never came.
    task automatic wait_ready(output int n);
        n = 99;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (ready === 1'b1) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        go_idle();
        addr = '0;
        tb_wdata = '0;
        exp_cnt = '0;
        tick();
        tick();
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready got %b want 0", ready); end
        checks++; if (conflict !== 1'b0) begin failures++; $display("FAIL reset_conflict got %b want 0", conflict); end
        checks++; if (access_cnt !== 16'h0000) begin failures++; $display("FAIL reset_cnt got %h want 0000", access_cnt); end
        checks++; if (data !== 16'hFFFF) begin failures++; $display("FAIL reset_bus got %h want FFFF (released)", data); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic_rw();
        int n;
        logic [15:0] e;
        do_write(18'h00010, 16'hBEEF, 1'b0, 1'b0, 1'b1);
        start_read(18'h00010, 1'b0, 1'b0, 16'hBEEF);
        wait_ready(n);
        e = sb_q.pop_front();
        checks++; if (n !== READ_LAT) begin failures++; $display("FAIL basic_latency got %0d want %0d", n, READ_LAT); end
        checks++; if (data !== e) begin failures++; $display("FAIL basic_data got %h want %h", data, e); end
        checks++; if (access_cnt !== exp_cnt) begin failures++; $display("FAIL basic_cnt got %h want %h", access_cnt, exp_cnt); end
        go_idle();
        tick();
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL basic_ready_drop got %b want 0", ready); end
    endtask

    task automatic test_byte_mask();
        int n;
        logic [15:0] e;
        do_write(18'h00020, 16'h1234, 1'b0, 1'b0, 1'b1);
        do_write(18'h00020, 16'hAB00, 1'b0, 1'b1, 1'b1);
        start_read(18'h00020, 1'b0, 1'b0, 16'hAB34);
        wait_ready(n);
        e = sb_q.pop_front();
        checks++; if (data !== e) begin failures++; $display("FAIL mask_merge got %h want %h", data, e); end
        go_idle();
        tick();
        start_read(18'h00020, 1'b1, 1'b0, 16'hAB34);
        wait_ready(n);
        e = sb_q.pop_front();
        checks++; if (data !== e) begin failures++; $display("FAIL mask_lane_read got %h want %h", data, e); end
        go_idle();
        tick();
    endtask

    task automatic test_alias();
        int n;
        logic [15:0] e;
        do_write(18'h01005, 16'h5555, 1'b0, 1'b0, 1'b1);
        start_read(18'h00005, 1'b0, 1'b0, 16'h5555);
        wait_ready(n);
        e = sb_q.pop_front();
        checks++; if (data !== e) begin failures++; $display("FAIL alias_data got %h want %h", data, e); end
        go_idle();
        tick();
    endtask

    task automatic test_comb_release();
        int n;
        logic [15:0] e;
        start_read(18'h00010, 1'b0, 1'b0, 16'hBEEF);
        wait_ready(n);
        e = sb_q.pop_front();
        checks++; if (data !== e) begin failures++; $display("FAIL comb_data got %h want %h", data, e); end
        #2 oute = 1'b1;
        #1;
        checks++; if (data !== 16'hFFFF) begin failures++; $display("FAIL comb_release got %h want FFFF", data); end
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL comb_ready_held got %b want 1", ready); end
        oute = 1'b0;
        lb_mask = 1'b1;
        #1;
        checks++; if (data !== 16'hBEFF) begin failures++; $display("FAIL comb_lane_gate got %h want BEFF", data); end
        go_idle();
        tick();
    endtask

    task automatic test_restart();
        int n;
        logic [15:0] e;
        start_read(18'h00010, 1'b0, 1'b0, 16'hBEEF);
        wait_ready(n);
        e = sb_q.pop_front();
        checks++; if (data !== e) begin failures++; $display("FAIL restart_first got %h want %h", data, e); end
        start_read(18'h00020, 1'b0, 1'b0, 16'hAB34);
        wait_ready(n);
        e = sb_q.pop_front();
        checks++; if (n !== READ_LAT) begin failures++; $display("FAIL restart_latency got %0d want %0d", n, READ_LAT); end
        checks++; if (data !== e) begin failures++; $display("FAIL restart_data got %h want %h", data, e); end
        checks++; if (access_cnt !== exp_cnt) begin failures++; $display("FAIL restart_cnt got %h want %h", access_cnt, exp_cnt); end
        go_idle();
        tick();
    endtask

    task automatic test_chip_select();
        int n;
        logic [15:0] e;
        chip_en  = 1'b1;
        wre      = 1'b0;
        addr     = 18'h00010;
        tb_wdata = 16'h9999;
        tb_drive = 1'b1;
        tick();
        go_idle();
        checks++; if (access_cnt !== exp_cnt) begin failures++; $display("FAIL cs_cnt got %h want %h", access_cnt, exp_cnt); end
        start_read(18'h00010, 1'b0, 1'b0, 16'hBEEF);
        wait_ready(n);
        e = sb_q.pop_front();
        checks++; if (data !== e) begin failures++; $display("FAIL cs_no_write got %h want %h", data, e); end
        go_idle();
        tick();
    endtask

    task automatic test_write_abort();
        int n;
        logic [15:0] e;
        do_write(18'h00040, 16'h1111, 1'b0, 1'b0, 1'b1);
        start_read(18'h00040, 1'b0, 1'b0, 16'h1111);
        wait_ready(n);
        e = sb_q.pop_front();
        checks++; if (data !== e) begin failures++; $display("FAIL abort_pre got %h want %h", data, e); end
        // Write over the presented word with output disabled.
        wre = 1'b0; oute = 1'b1; tb_wdata = 16'h0F0F; tb_drive = 1'b1;
        exp_cnt++;
        tick();
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL abort_ready got %b want 0", ready); end
        checks++; if (conflict !== 1'b0) begin failures++; $display("FAIL abort_no_conflict got %b want 0", conflict); end
        go_idle();
        start_read(18'h00040, 1'b0, 1'b0, 16'h0F0F);
        wait_ready(n);
        e = sb_q.pop_front();
        checks++; if (data !== e) begin failures++; $display("FAIL abort_readback got %h want %h", data, e); end
        // Write with output enable still low: conflict, write still lands.
        wre = 1'b0; tb_wdata = 16'h7070; tb_drive = 1'b1;
        exp_cnt++;
        #1;
        checks++; if (data !== 16'h7070) begin failures++; $display("FAIL conflict_bus got %h want 7070", data); end
        tick();
        checks++; if (conflict !== 1'b1) begin failures++; $display("FAIL conflict_set got %b want 1", conflict); end
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL conflict_ready got %b want 0", ready); end
        go_idle();
        tick();
        tick();
        checks++; if (conflict !== 1'b1) begin failures++; $display("FAIL conflict_sticky got %b want 1", conflict); end
        start_read(18'h00040, 1'b0, 1'b0, 16'h7070);
        wait_ready(n);
        e = sb_q.pop_front();
        checks++; if (data !== e) begin failures++; $display("FAIL conflict_write got %h want %h", data, e); end
        checks++; if (access_cnt !== exp_cnt) begin failures++; $display("FAIL conflict_cnt got %h want %h", access_cnt, exp_cnt); end
        go_idle();
        tick();
    endtask

    task automatic test_reset_midread();
        int n;
        logic [15:0] e;
        // Reset while waiting for read latency.
        chip_en = 1'b0; wre = 1'b1; oute = 1'b0; addr = 18'h00010;
        tick();
        #2 reset = 1'b0;
        #1;
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL rstwait_ready got %b want 0", ready); end
        checks++; if (access_cnt !== 16'h0000) begin failures++; $display("FAIL rstwait_cnt got %h want 0000", access_cnt); end
        checks++; if (conflict !== 1'b0) begin failures++; $display("FAIL rstwait_conflict got %b want 0", conflict); end
        checks++; if (data !== 16'hFFFF) begin failures++; $display("FAIL rstwait_bus got %h want FFFF", data); end
        go_idle();
        tick();
        reset = 1'b1;
        tick();
        // Reset while data is on the bus.
        chip_en = 1'b0; wre = 1'b1; oute = 1'b0; addr = 18'h00010;
        for (int k = 0; k < READ_LAT; k++) tick();
        checks++; if (data !== 16'hBEEF) begin failures++; $display("FAIL rstdrv_pre got %h want BEEF", data); end
        #2 reset = 1'b0;
        #1;
        checks++; if (data !== 16'hFFFF) begin failures++; $display("FAIL rstdrv_release got %h want FFFF", data); end
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL rstdrv_ready got %b want 0", ready); end
        go_idle();
        tick();
        reset = 1'b1;
        exp_cnt = '0;
        tick();
        start_read(18'h00010, 1'b0, 1'b0, 16'hBEEF);
        wait_ready(n);
        e = sb_q.pop_front();
        checks++; if (data !== e) begin failures++; $display("FAIL rst_keeps_mem got %h want %h", data, e); end
        checks++; if (access_cnt !== exp_cnt) begin failures++; $display("FAIL rst_cnt_resume got %h want %h", access_cnt, exp_cnt); end
        go_idle();
        tick();
    endtask

    task automatic test_wrap();
        go_idle();
        reset = 1'b0;
        #1 reset = 1'b1;
        exp_cnt = '0;
        chip_en = 1'b0; wre = 1'b0; oute = 1'b1; tb_drive = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            addr = 18'(i);
            tb_wdata = 16'(i);
            exp_cnt++;
            tick();
        end
        checks++; if (access_cnt !== 16'hFFFF) begin failures++; $display("FAIL wrap_max got %h want FFFF", access_cnt); end
        exp_cnt++;
        tick();
        checks++; if (access_cnt !== exp_cnt) begin failures++; $display("FAIL wrap_zero got %h want %h", access_cnt, exp_cnt); end
        go_idle();
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_rw();
        test_byte_mask();
        test_alias();
        test_comb_release();
        test_restart();
        test_chip_select();
        test_write_abort();
        test_reset_midread();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
